// File: rtl/mcp3x08_scanner.sv
// Round-robin SPI scanner for MCP3008 (10-bit) / MCP3208 (12-bit) ADCs, one 24-bit frame per conversion.
// Define MCP_OVERSAMPLE_EN to average four consecutive conversions of a channel per published sample.
module mcp3x08_scanner #(
  parameter int ADC_BITS = 10,
  parameter int CHANNELS = 8,
  parameter int CS_GAP   = 2
) (
  input  logic                         SCLK,
  input  logic                         reset_n,
  input  logic                         enable,
  input  logic                         diff_mode,
  input  logic [CHANNELS-1:0]          chan_mask,
  input  logic                         SPI_IN,
  output logic                         SPI_OUT,
  output logic                         CS_n,
  output logic                         sample_valid,
  output logic [2:0]                   sample_chan,
  output logic [ADC_BITS-1:0]          sample_data,
  output logic [CHANNELS*ADC_BITS-1:0] ch_data,
  output logic                         busy,
  output logic                         scan_done
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_GAP   = 2'd3;

  localparam int START_POS = ADC_BITS + 6;
  localparam int GAP_W     = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

  logic [1:0]          state;
  logic [4:0]          bit_cnt;
  logic [4:0]          tx_pos;
  logic [GAP_W-1:0]    gap_cnt;
  logic [2:0]          chan_q;
  logic [2:0]          last_chan;
  logic [2:0]          next_chan;
  logic [2:0]          high_chan;
  logic                last_valid;
  logic                next_found;
  logic                sgl_q;
  logic                tx_bit;
  logic                start_ok;
  logic                frame_last;
  logic                new_group;
  logic                group_open;
  logic [CHANNELS-1:0] mask_q;
  logic [ADC_BITS-1:0] rx_shift;
  logic [ADC_BITS-1:0] pub_data;

  assign start_ok = enable && (|chan_mask);
  assign busy     = (state != ST_IDLE);

  // Lowest enabled channel strictly above the last one converted, wrapping to the lowest enabled one.
  always_comb begin
    next_chan  = '0;
    next_found = 1'b0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (chan_mask[i] && (!last_valid || (3'(i) > last_chan))) begin
        next_chan  = 3'(i);
        next_found = 1'b1;
      end
    end
    if (!next_found) begin
      for (int i = CHANNELS - 1; i >= 0; i--) begin
        if (chan_mask[i]) next_chan = 3'(i);
      end
    end
  end

  always_comb begin
    high_chan = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (mask_q[i]) high_chan = 3'(i);
    end
  end

  // Command bit for the counter position the next SHIFT cycle will present.
  always_comb begin
    tx_pos = bit_cnt - 5'd1;
    tx_bit = 1'b0;
    if (int'(tx_pos) == START_POS)          tx_bit = 1'b1;
    else if (int'(tx_pos) == START_POS - 1) tx_bit = sgl_q;
    else if (int'(tx_pos) == START_POS - 2) tx_bit = chan_q[2];
    else if (int'(tx_pos) == START_POS - 3) tx_bit = chan_q[1];
    else if (int'(tx_pos) == START_POS - 4) tx_bit = chan_q[0];
  end

`ifdef MCP_OVERSAMPLE_EN
  logic [1:0]          os_cnt;
  logic [ADC_BITS+1:0] acc;
  logic [ADC_BITS+1:0] acc_sum;

  assign acc_sum    = acc + {2'b00, rx_shift};
  assign pub_data   = acc_sum[ADC_BITS+1:2];
  assign frame_last = (os_cnt == 2'd3);
  assign new_group  = (os_cnt == 2'd0);
  assign group_open = (os_cnt != 2'd0);

  // os_cnt wraps 3 -> 0 after the fourth frame, reopening channel selection.
  always_ff @(posedge SCLK or negedge reset_n) begin
    if (!reset_n) begin
      os_cnt <= 2'd0;
      acc    <= '0;
    end else if (state == ST_LOAD && os_cnt == 2'd0) begin
      acc <= '0;
    end else if (state == ST_SHIFT && bit_cnt == 5'd0) begin
      acc    <= acc_sum;
      os_cnt <= os_cnt + 2'd1;
    end
  end
`else
  assign pub_data   = rx_shift;
  assign frame_last = 1'b1;
  assign new_group  = 1'b1;
  assign group_open = 1'b0;
`endif

  always_ff @(posedge SCLK or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      bit_cnt      <= '0;
      gap_cnt      <= '0;
      chan_q       <= '0;
      last_chan    <= '0;
      last_valid   <= 1'b0;
      sgl_q        <= 1'b0;
      mask_q       <= '0;
      SPI_OUT      <= 1'b0;
      CS_n         <= 1'b1;
      sample_valid <= 1'b0;
      sample_chan  <= '0;
      sample_data  <= '0;
      ch_data      <= '0;
      scan_done    <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      scan_done    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_ok) state <= ST_LOAD;
        end
        ST_LOAD: begin
          if (new_group) begin
            chan_q     <= next_chan;
            last_chan  <= next_chan;
            last_valid <= 1'b1;
            mask_q     <= chan_mask;
            sgl_q      <= ~diff_mode;
          end
          bit_cnt <= 5'd23;
          CS_n    <= 1'b0;
          SPI_OUT <= 1'b0;
          state   <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (bit_cnt == 5'd0) begin
            state   <= ST_GAP;
            CS_n    <= 1'b1;
            SPI_OUT <= 1'b0;
            gap_cnt <= GAP_W'(CS_GAP - 1);
            if (frame_last) begin
              sample_valid <= 1'b1;
              sample_chan  <= chan_q;
              sample_data  <= pub_data;
              scan_done    <= (chan_q == high_chan);
              for (int i = 0; i < CHANNELS; i++) begin
                if (chan_q == 3'(i)) ch_data[i*ADC_BITS +: ADC_BITS] <= pub_data;
              end
            end
          end else begin
            bit_cnt <= bit_cnt - 5'd1;
            SPI_OUT <= tx_bit;
          end
        end
        ST_GAP: begin
          if (gap_cnt == '0) state <= (group_open || start_ok) ? ST_LOAD : ST_IDLE;
          else gap_cnt <= gap_cnt - GAP_W'(1);
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // DOUT is sampled mid-bit on the falling edge; only the last ADC_BITS bits survive the shift.
  always_ff @(negedge SCLK or negedge reset_n) begin
    if (!reset_n) rx_shift <= '0;
    else if (state == ST_SHIFT) rx_shift <= {rx_shift[ADC_BITS-2:0], SPI_IN};
  end

endmodule

// File: tb/tb_mcp3x08_scanner.sv
// Scoreboard bench for mcp3x08_scanner: 10-bit and 12-bit instances, each driven by a behavioural ADC.
// Build with MCP_OVERSAMPLE_EN defined to run the oversampling sequence instead of the default one.
module tb_mcp3x08_scanner;

  typedef struct packed {
    logic [2:0]  chan;
    logic [11:0] data;
    logic        done;
  } exp_t;

  logic SCLK;
  logic reset_n;
  logic en10, diff10, si10;
  logic [7:0] mask10;
  logic so10, cs10, sv10, sd_done10, busy10;
  logic [2:0] sc10;
  logic [9:0] sdat10;
  logic [79:0] chd10;
  logic en12, diff12, si12;
  logic [7:0] mask12;
  logic so12, cs12, sv12, sd_done12, busy12;
  logic [2:0] sc12;
  logic [11:0] sdat12;
  logic [95:0] chd12;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  exp_t q10[$];
  exp_t q12[$];
  int seen10 = 0, seen12 = 0;
  int last_sv10 = -1, period10 = 0;

  int k10 = 0, cnt10 = -1, frames10 = 0, cs_low10 = 0, mode10 = 0, os_idx10 = 0;
  logic [23:0] fr10, last_fr10;
  logic [9:0] res10;
  int k12 = 0, cnt12 = -1;
  logic [23:0] fr12, last_fr12;
  logic [11:0] res12;
  logic [9:0] os_vals [4] = '{10'd100, 10'd101, 10'd102, 10'd104};

  mcp3x08_scanner #(.ADC_BITS(10), .CHANNELS(8), .CS_GAP(2)) u10 (
    .SCLK(SCLK), .reset_n(reset_n), .enable(en10), .diff_mode(diff10), .chan_mask(mask10),
    .SPI_IN(si10), .SPI_OUT(so10), .CS_n(cs10), .sample_valid(sv10), .sample_chan(sc10),
    .sample_data(sdat10), .ch_data(chd10), .busy(busy10), .scan_done(sd_done10)
  );

  mcp3x08_scanner #(.ADC_BITS(12), .CHANNELS(8), .CS_GAP(2)) u12 (
    .SCLK(SCLK), .reset_n(reset_n), .enable(en12), .diff_mode(diff12), .chan_mask(mask12),
    .SPI_IN(si12), .SPI_OUT(so12), .CS_n(cs12), .sample_valid(sv12), .sample_chan(sc12),
    .sample_data(sdat12), .ch_data(chd12), .busy(busy12), .scan_done(sd_done12)
  );

  initial begin
    SCLK = 1'b0;
    forever #5 SCLK = ~SCLK;
  end

  always @(posedge SCLK) cyc++;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic [7:0] mask, input logic diff);
    en10   = en;
    mask10 = mask;
    diff10 = diff;
  endtask

  function automatic logic [9:0] adc_value10(input logic [2:0] ch);
    if (mode10 == 0) return 10'h2A5;
    if (mode10 == 1) return 10'(12'h100 + 12'(ch));
    return os_vals[os_idx10 % 4];
  endfunction

  // ADC model, 10-bit part: decodes the command from DIN and drives DOUT for the counter position.
  always @(posedge SCLK) begin
    #1;
    if (cs10 === 1'b0) begin
      cnt10 = 23 - k10;
      fr10[cnt10] = so10;
      if (cnt10 == 12) res10 = adc_value10({fr10[14], fr10[13], fr10[12]});
      si10 = (cnt10 < 10) ? res10[cnt10] : 1'b0;
      k10++;
    end else begin
      if (k10 != 0) begin
        last_fr10 = fr10;
        cs_low10 = k10;
        frames10++;
        os_idx10++;
      end
      k10 = 0;
      cnt10 = -1;
      si10 = 1'b0;
    end
  end

  always @(posedge SCLK) begin
    #1;
    if (cs12 === 1'b0) begin
      cnt12 = 23 - k12;
      fr12[cnt12] = so12;
      if (cnt12 == 14) res12 = 12'hABC;
      si12 = (cnt12 < 12) ? res12[cnt12] : 1'b0;
      k12++;
    end else begin
      if (k12 != 0) last_fr12 = fr12;
      k12 = 0;
      cnt12 = -1;
      si12 = 1'b0;
    end
  end

  // Scoreboard side: every published sample pops one expectation.
  always @(negedge SCLK) begin
    exp_t e;
    if (sv10 === 1'b1) begin
      checkOutput("q10_has_entry", 32'(q10.size() > 0), 32'd1);
      if (q10.size() > 0) begin
        e = q10.pop_front();
        checkOutput("chan10", 32'(sc10), 32'(e.chan));
        checkOutput("data10", 32'(sdat10), 32'(e.data));
        checkOutput("scan_done10", 32'(sd_done10), 32'(e.done));
        checkOutput("ch_data10", 32'(chd10[int'(e.chan)*10 +: 10]), 32'(e.data));
      end
      if (last_sv10 >= 0) period10 = cyc - last_sv10;
      last_sv10 = cyc;
      seen10++;
    end else if (sd_done10 === 1'b1) begin
      checkOutput("scan_done10_stray", 32'(sd_done10), 32'd0);
    end
    if (sv12 === 1'b1) begin
      checkOutput("q12_has_entry", 32'(q12.size() > 0), 32'd1);
      if (q12.size() > 0) begin
        e = q12.pop_front();
        checkOutput("chan12", 32'(sc12), 32'(e.chan));
        checkOutput("data12", 32'(sdat12), 32'(e.data));
        checkOutput("scan_done12", 32'(sd_done12), 32'(e.done));
        checkOutput("ch_data12", 32'(chd12[int'(e.chan)*12 +: 12]), 32'(e.data));
      end
      seen12++;
    end
  end

  task automatic wait_seen(input int which, input int target, input int budget);
    int n = 0;
    while (((which == 0) ? seen10 : seen12) < target && n < budget) begin
      @(negedge SCLK);
      n++;
    end
    checkOutput("sample_wait", 32'(((which == 0) ? seen10 : seen12) >= target), 32'd1);
  endtask

  task automatic wait_cnt10(input int target, input int budget);
    int n = 0;
    while (n < budget) begin
      @(posedge SCLK);
      #2;
      if (cnt10 == target) break;
      n++;
    end
    checkOutput("counter_wait", 32'(cnt10 == target), 32'd1);
  endtask

  task automatic wait_idle10(input int budget);
    int n = 0;
    while (busy10 !== 1'b0 && n < budget) begin
      @(negedge SCLK);
      n++;
    end
    checkOutput("idle_wait", 32'(busy10), 32'd0);
  endtask

  task automatic pulse_reset();
    @(negedge SCLK);
    reset_n = 1'b0;
    repeat (2) @(negedge SCLK);
    reset_n = 1'b1;
  endtask

  initial begin
    int f0;
    reset_n = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b0);
    en12 = 1'b0; mask12 = 8'h00; diff12 = 1'b0;
    repeat (3) @(negedge SCLK);
    checkOutput("rst_cs_n", 32'(cs10), 32'd1);
    checkOutput("rst_spi_out", 32'(so10), 32'd0);
    checkOutput("rst_valid", 32'(sv10), 32'd0);
    checkOutput("rst_data", 32'(sdat10), 32'd0);
    checkOutput("rst_chan", 32'(sc10), 32'd0);
    checkOutput("rst_ch_data", 32'(|chd10), 32'd0);
    checkOutput("rst_busy", 32'(busy10), 32'd0);
    checkOutput("rst_scan_done", 32'(sd_done10), 32'd0);
    checkOutput("rst_cs_n12", 32'(cs12), 32'd1);
    reset_n = 1'b1;

`ifdef MCP_OVERSAMPLE_EN
    mode10 = 2;
    os_idx10 = 0;
    f0 = frames10;
    q10.push_back('{chan: 3'd3, data: 12'd101, done: 1'b1});
    applyStimulus(1'b1, 8'h08, 1'b0);
    wait_seen(0, 1, 400);
    applyStimulus(1'b0, 8'h08, 1'b0);
    wait_idle10(40);
    checkOutput("os_frames", 32'(frames10 - f0), 32'd4);
`else
    // Single channel, constant conversion value
    mode10 = 0;
    repeat (3) q10.push_back('{chan: 3'd0, data: 12'h2A5, done: 1'b1});
    applyStimulus(1'b1, 8'h01, 1'b0);
    wait_seen(0, 3, 200);
    checkOutput("period10", 32'(period10), 32'd27);
    checkOutput("frame10", 32'(last_fr10), 32'h018000);
    checkOutput("cs_low10", 32'(cs_low10), 32'd24);
    applyStimulus(1'b0, 8'h01, 1'b0);
    wait_idle10(40);

    // Sparse mask scan from a fresh reset
    pulse_reset();
    mode10 = 1;
    q10.push_back('{chan: 3'd0, data: 12'h100, done: 1'b0});
    q10.push_back('{chan: 3'd2, data: 12'h102, done: 1'b0});
    q10.push_back('{chan: 3'd5, data: 12'h105, done: 1'b0});
    q10.push_back('{chan: 3'd7, data: 12'h107, done: 1'b1});
    q10.push_back('{chan: 3'd0, data: 12'h100, done: 1'b0});
    applyStimulus(1'b1, 8'hA5, 1'b0);
    wait_seen(0, 8, 400);
    checkOutput("ch_data10_ch0", 32'(chd10[9:0]), 32'h100);
    checkOutput("ch_data10_ch2", 32'(chd10[29:20]), 32'h102);
    checkOutput("ch_data10_ch5", 32'(chd10[59:50]), 32'h105);
    checkOutput("ch_data10_ch7", 32'(chd10[79:70]), 32'h107);
    checkOutput("ch_data10_ch1", 32'(chd10[19:10]), 32'h000);

    // Disable mid-frame: the channel-2 frame still completes
    wait_cnt10(10, 100);
    q10.push_back('{chan: 3'd2, data: 12'h102, done: 1'b0});
    applyStimulus(1'b0, 8'hA5, 1'b0);
    wait_seen(0, 9, 100);
    wait_idle10(10);
    checkOutput("cs_n_disabled", 32'(cs10), 32'd1);
    f0 = frames10;
    repeat (60) @(negedge SCLK);
    checkOutput("no_frames_disabled", 32'(frames10), 32'(f0));
    checkOutput("busy_disabled", 32'(busy10), 32'd0);
    q10.push_back('{chan: 3'd5, data: 12'h105, done: 1'b0});
    applyStimulus(1'b1, 8'hA5, 1'b0);
    wait_seen(0, 10, 100);

    // Reset mid-frame (channel 7 in flight)
    wait_cnt10(12, 100);
    reset_n = 1'b0;
    #1;
    checkOutput("midrst_cs_n", 32'(cs10), 32'd1);
    checkOutput("midrst_valid", 32'(sv10), 32'd0);
    checkOutput("midrst_data", 32'(sdat10), 32'd0);
    checkOutput("midrst_ch_data", 32'(|chd10), 32'd0);
    checkOutput("midrst_busy", 32'(busy10), 32'd0);
    repeat (2) @(negedge SCLK);
    reset_n = 1'b1;
    q10.push_back('{chan: 3'd0, data: 12'h100, done: 1'b0});
    wait_seen(0, 11, 100);
    checkOutput("post_rst_upper", 32'(|chd10[79:10]), 32'd0);
    applyStimulus(1'b0, 8'hA5, 1'b0);
    wait_idle10(40);

    // 12-bit part, pseudo-differential channel 3
    q12.push_back('{chan: 3'd3, data: 12'hABC, done: 1'b1});
    mask12 = 8'h08; diff12 = 1'b1; en12 = 1'b1;
    wait_seen(1, 1, 100);
    checkOutput("frame12", 32'(last_fr12), 32'h04C000);
    en12 = 1'b0;
    repeat (10) @(negedge SCLK);
    checkOutput("busy12_idle", 32'(busy12), 32'd0);
`endif

    checkOutput("q10_drained", 32'(q10.size()), 32'd0);
    checkOutput("q12_drained", 32'(q12.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
